// File: rtl/m_axi4_fsb_adapter.sv
// Packs 80-bit FSB packets into 64-byte lines and writes each line to a host
// ring buffer with single-beat AXI4 bursts, one write outstanding at a time.
module m_axi4_fsb_adapter #(
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int unsigned RING_LINES = 64,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic         fsb_v_i,
    input  logic [79:0]  fsb_data_i,
    output logic         fsb_r_o,
    output logic [63:0]  awaddr_o,
    output logic [7:0]   awlen_o,
    output logic [2:0]   awsize_o,
    output logic         awvalid_o,
    input  logic         awready_i,
    output logic [511:0] wdata_o,
    output logic [63:0]  wstrb_o,
    output logic         wlast_o,
    output logic         wvalid_o,
    input  logic         wready_i,
    input  logic [1:0]   bresp_i,
    input  logic         bvalid_i,
    output logic         bready_o,
    input  logic [7:0]   rd_ptr_i,
    output logic [7:0]   wr_ptr_o,
    output logic         err_o
);

    typedef enum logic [1:0] {StFill, StSend, StResp} state_e;

    localparam logic [7:0] PtrMask = 8'(RING_LINES - 1);
    localparam logic [7:0] IdleMax = 8'(TIMEOUT);

    state_e         state_q, state_d;
    logic [2:0]     slots_q, slots_d;
    logic [7:0]     idle_q, idle_d;
    logic [7:0]     wr_ptr_q, wr_ptr_d;
    logic           err_q, err_d;
    logic           aw_pend_q, aw_pend_d;
    logic           w_pend_q, w_pend_d;
    logic [511:0]   data_q, data_d;
    logic [63:0]    strb_q, strb_d;

    logic           accept;
    logic           line_ready;
    logic           ring_full;
    logic [7:0]     ptr_next;
    logic           aw_done;
    logic           w_done;

    assign fsb_r_o   = (state_q == StFill) && (slots_q < 3'd4);
    assign accept    = fsb_v_i && fsb_r_o;
    assign ptr_next  = (wr_ptr_q + 8'd1) & PtrMask;
    // rd_ptr_i is used combinationally so a host update unblocks this cycle
    assign ring_full = (ptr_next == rd_ptr_i);
    assign aw_done   = !aw_pend_q || awready_i;
    assign w_done    = !w_pend_q || wready_i;

    always_comb begin
        state_d    = state_q;
        slots_d    = slots_q;
        idle_d     = idle_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = err_q;
        aw_pend_d  = aw_pend_q;
        w_pend_d   = w_pend_q;
        data_d     = data_q;
        strb_d     = strb_q;
        line_ready = 1'b0;

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    data_d[{slots_q[1:0], 7'd0} +: 128] = {48'h0, fsb_data_i};
                    strb_d[{slots_q[1:0], 4'd0} +: 16]  = 16'hFFFF;
                    slots_d = slots_q + 3'd1;
                    idle_d  = 8'd0;
                end else if (slots_q == 3'd0) begin
                    idle_d = 8'd0;
                end else if (idle_q != IdleMax) begin
                    idle_d = idle_q + 8'd1;
                end
                // Look at slots_d so the fourth packet launches the write next cycle
                line_ready = (slots_d == 3'd4) || ((slots_q != 3'd0) && (idle_q == IdleMax));
                if (line_ready && !ring_full) begin
                    state_d   = StSend;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                end
            end
            StSend: begin
                if (awready_i) aw_pend_d = 1'b0;
                if (wready_i) w_pend_d = 1'b0;
                if (aw_done && w_done) state_d = StResp;
            end
            StResp: begin
                if (bvalid_i) begin
                    wr_ptr_d = ptr_next;
                    if (bresp_i != 2'b00) err_d = 1'b1;
                    slots_d  = 3'd0;
                    idle_d   = 8'd0;
                    data_d   = '0;
                    strb_d   = '0;
                    state_d  = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q   <= StFill;
            slots_q   <= 3'd0;
            idle_q    <= 8'd0;
            wr_ptr_q  <= 8'd0;
            err_q     <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            slots_q   <= slots_d;
            idle_q    <= idle_d;
            wr_ptr_q  <= wr_ptr_d;
            err_q     <= err_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

    assign awvalid_o = (state_q == StSend) && aw_pend_q;
    assign wvalid_o  = (state_q == StSend) && w_pend_q;
    assign bready_o  = (state_q == StResp);
    assign awaddr_o  = BASE_ADDR + {50'h0, wr_ptr_q, 6'h0};
    assign awlen_o   = 8'd0;
    assign awsize_o  = 3'b110;
    assign wlast_o   = 1'b1;
    assign wdata_o   = data_q;
    assign wstrb_o   = strb_q;
    assign wr_ptr_o  = wr_ptr_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_m_axi4_fsb_adapter.sv
// Directed bench for m_axi4_fsb_adapter: line packing, timeout flush, ring-full
// back-pressure, split AW/W handshakes, error response and reset abort.
module tb_m_axi4_fsb_adapter;

    localparam logic [63:0] Base  = 64'h0000_0001_2340_0000;
    localparam int unsigned Lines = 64;

    logic         clk = 1'b0;
    logic         resetn;
    logic         fsb_v;
    logic [79:0]  fsb_data;
    logic         fsb_r;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         awvalid;
    logic         awready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   rd_ptr;
    logic [7:0]   wr_ptr;
    logic         err;

    int vectors = 0;
    int fails = 0;
    int exp_ptr = 0;
    int exp_writes = 0;
    int aw_hs = 0;
    int n;

    m_axi4_fsb_adapter #(
        .BASE_ADDR (Base),
        .RING_LINES(Lines),
        .TIMEOUT   (16)
    ) dut (
        .clk_i     (clk),
        .resetn_i  (resetn),
        .fsb_v_i   (fsb_v),
        .fsb_data_i(fsb_data),
        .fsb_r_o   (fsb_r),
        .awaddr_o  (awaddr),
        .awlen_o   (awlen),
        .awsize_o  (awsize),
        .awvalid_o (awvalid),
        .awready_i (awready),
        .wdata_o   (wdata),
        .wstrb_o   (wstrb),
        .wlast_o   (wlast),
        .wvalid_o  (wvalid),
        .wready_i  (wready),
        .bresp_i   (bresp),
        .bvalid_i  (bvalid),
        .bready_o  (bready),
        .rd_ptr_i  (rd_ptr),
        .wr_ptr_o  (wr_ptr),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (awvalid && awready) aw_hs <= aw_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push4(input logic [79:0] seed);
        for (int k = 0; k < 4; k++) begin
            fsb_v    = 1'b1;
            fsb_data = seed + 80'(k);
            tick();
        end
        fsb_v = 1'b0;
    endtask

    // Full line through the AXI handshake with awready/wready held high.
    task automatic do_line(input logic [79:0] seed, input logic [1:0] resp);
        int m;
        push4(seed);
        m = 0;
        while (!awvalid && m < 20) begin tick(); m++; end
        chk("line_awvalid", awvalid, 1'b1);
        chk("line_awaddr", awaddr, Base + 64'(exp_ptr) * 64);
        m = 0;
        while (!bready && m < 20) begin tick(); m++; end
        chk("line_bready", bready, 1'b1);
        bresp  = resp;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        bresp  = 2'b00;
        exp_ptr = (exp_ptr + 1) % Lines;
        exp_writes++;
        chk("line_wr_ptr", wr_ptr, 8'(exp_ptr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        fsb_v    = 1'b0;
        fsb_data = '0;
        awready  = 1'b1;
        wready   = 1'b1;
        bresp    = 2'b00;
        bvalid   = 1'b0;
        rd_ptr   = 8'd0;
        tick();
        chk("rst_fsb_r", fsb_r, 1'b1);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_wr_ptr", wr_ptr, 8'd0);
        chk("rst_err", err, 1'b0);
        resetn = 1'b1;
        tick();

        // Four back-to-back packets: write one cycle after the fourth.
        push4(80'h1);
        chk("b2b_awvalid", awvalid, 1'b1);
        chk("b2b_wvalid", wvalid, 1'b1);
        chk("b2b_fsb_r", fsb_r, 1'b0);
        chk("b2b_awaddr", awaddr, Base);
        chk("b2b_awlen", awlen, 8'd0);
        chk("b2b_awsize", awsize, 3'b110);
        chk("b2b_wlast", wlast, 1'b1);
        chk("b2b_slot0", wdata[79:0], 80'h1);
        chk("b2b_pad0", wdata[127:80], 48'h0);
        chk("b2b_slot1", wdata[207:128], 80'h2);
        chk("b2b_slot3", wdata[463:384], 80'h4);
        chk("b2b_wstrb", wstrb, {64{1'b1}});
        tick();
        chk("b2b_resp_aw", awvalid, 1'b0);
        chk("b2b_resp_w", wvalid, 1'b0);
        chk("b2b_resp_bready", bready, 1'b1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        exp_ptr = 1;
        exp_writes++;
        chk("b2b_wr_ptr", wr_ptr, 8'd1);
        chk("b2b_fill_fsb_r", fsb_r, 1'b1);
        chk("b2b_fill_bready", bready, 1'b0);
        chk("b2b_err", err, 1'b0);

        // Single packet then idle: counter reaches 16, write the cycle after.
        fsb_v    = 1'b1;
        fsb_data = 80'hABC_DEF0;
        tick();
        fsb_v = 1'b0;
        n = 0;
        while (!awvalid && n < 40) begin tick(); n++; end
        chk("to_latency", 32'(n), 32'd17);
        chk("to_wstrb", wstrb, 64'h0000_0000_0000_FFFF);
        chk("to_wdata", wdata, 80'hABC_DEF0);
        chk("to_awaddr", awaddr, Base + 64'd64);
        tick();
        chk("to_bready", bready, 1'b1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        exp_ptr = 2;
        exp_writes++;
        chk("to_wr_ptr", wr_ptr, 8'd2);

        // AW accepted at once, W held off: AW drops, W stays up five cycles.
        wready = 1'b0;
        push4(80'h100);
        chk("split_aw0", awvalid, 1'b1);
        chk("split_w0", wvalid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("split_aw_low", awvalid, 1'b0);
            chk("split_w_high", wvalid, 1'b1);
            chk("split_no_bready", bready, 1'b0);
        end
        wready = 1'b1;
        tick();
        chk("split_w_done", wvalid, 1'b0);
        chk("split_resp", bready, 1'b1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        exp_ptr = 3;
        exp_writes++;
        chk("split_wr_ptr", wr_ptr, 8'd3);
        chk("split_single_aw", 32'(aw_hs), 32'(exp_writes));

        // Error response: err sticks, pointer still advances; reset clears.
        do_line(80'h200, 2'b10);
        chk("err_set", err, 1'b1);
        do_line(80'h300, 2'b00);
        chk("err_sticky", err, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        exp_ptr = 0;
        chk("err_rst_err", err, 1'b0);
        chk("err_rst_ptr", wr_ptr, 8'd0);

        // Ring full: fill Lines-1 lines with rd_ptr at 0, next line must wait.
        for (int i = 0; i < Lines - 1; i++) do_line(80'(i * 16), 2'b00);
        chk("full_wr_ptr", wr_ptr, 8'(Lines - 1));
        push4(80'h500);
        chk("full_fsb_r", fsb_r, 1'b0);
        chk("full_no_aw", awvalid, 1'b0);
        repeat (6) tick();
        chk("full_hold_aw", awvalid, 1'b0);
        chk("full_hold_fsb_r", fsb_r, 1'b0);
        chk("full_hold_hs", 32'(aw_hs), 32'(exp_writes));
        rd_ptr = 8'd1;
        tick();
        chk("unfull_aw", awvalid, 1'b1);
        chk("unfull_awaddr", awaddr, Base + 64'(Lines - 1) * 64);
        chk("unfull_slot0", wdata[79:0], 80'h500);
        tick();
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        exp_writes++;
        exp_ptr = 0;
        chk("wrap_wr_ptr", wr_ptr, 8'd0);
        rd_ptr = 8'd40;

        // Reset while AW is pending abandons the write.
        do_line(80'h600, 2'b00);
        awready = 1'b0;
        push4(80'h700);
        chk("abort_aw_pending", awvalid, 1'b1);
        tick();
        chk("abort_aw_still", awvalid, 1'b1);
        resetn = 1'b0;
        tick();
        chk("abort_awvalid", awvalid, 1'b0);
        chk("abort_wvalid", wvalid, 1'b0);
        chk("abort_bready", bready, 1'b0);
        chk("abort_wr_ptr", wr_ptr, 8'd0);
        chk("abort_fsb_r", fsb_r, 1'b1);
        resetn  = 1'b1;
        awready = 1'b1;
        repeat (3) tick();
        chk("abort_no_resume", awvalid, 1'b0);
        chk("abort_wstrb", wstrb, 64'h0);
        chk("total_aw_hs", 32'(aw_hs), 32'(exp_writes));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/m_axi4_fsb_adapter.md
M_AXI4_FSB_ADAPTER -- requirements
Module: m_axi4_fsb_adapter

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 64'h0: byte address of the host ring buffer, 64-byte aligned.
REQ-002 The block SHALL have parameter RING_LINES, default 64: number of 64-byte lines in the ring, power of two, 2..256.
REQ-003 The block SHALL have parameter TIMEOUT, default 16: idle cycles before a partial line is flushed, 1..255.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk_i  in  1  clock; resetn_i  in  1  synchronous active-low reset.
REQ-005 The block SHALL have these FSB packet ports: fsb_v_i  in  1  packet valid; fsb_data_i  in  80  packet; fsb_r_o  out  1  ready.
REQ-006 The block SHALL have these AXI4 write-address ports: awaddr_o  out  64; awlen_o  out  8; awsize_o  out  3; awvalid_o  out  1; awready_i  in  1.
REQ-007 The block SHALL have these AXI4 write-data ports: wdata_o  out  512; wstrb_o  out  64; wlast_o  out  1; wvalid_o  out  1; wready_i  in  1.
REQ-008 The block SHALL have these AXI4 write-response ports: bresp_i  in  2; bvalid_i  in  1; bready_o  out  1.
REQ-009 The block SHALL have these ring-control ports: rd_ptr_i  in  8  host consumer line index; wr_ptr_o  out  8  producer line index; err_o  out  1  sticky bad-response flag.

Function
REQ-010 The block SHALL accept a packet only on a cycle where fsb_v_i & fsb_r_o are both 1.
REQ-011 The block SHALL place accepted packet k (0..3) of a line at wdata bits [128k+79:128k], zero bits [128k+127:128k+80], and set wstrb bits [16k+15:16k] to all ones.
REQ-012 Unfilled slots SHALL carry zero data and zero strobes.
REQ-013 The block SHALL implement states FILL, SEND and RESP, with FILL as the reset state.
REQ-014 fsb_r_o SHALL be 1 only in FILL with fewer than 4 slots filled.
REQ-015 The line SHALL become ready when 4 slots are filled, or when at least 1 slot is filled and the idle counter equals TIMEOUT.
REQ-016 The idle counter SHALL clear on every accepted packet and while the line is empty, increment each FILL cycle otherwise, and saturate at TIMEOUT.
REQ-017 The ring SHALL be full when ((wr_ptr_o+1) mod RING_LINES) == rd_ptr_i.
REQ-018 FILL SHALL go to SEND on the cycle after the line is ready and the ring is not full.
REQ-019 While the ring is full, the block SHALL hold the ready line in FILL, with no AXI activity.
REQ-020 In SEND, awvalid_o and wvalid_o SHALL both assert on entry, and each SHALL drop independently the cycle after its own handshake.
REQ-021 SEND SHALL go to RESP once both the AW and W handshakes have completed, in any order, including the same cycle.
REQ-022 Each write SHALL use awaddr_o = BASE_ADDR + wr_ptr_o*64, awlen_o = 0, awsize_o = 3'b110 and wlast_o = 1, with all values stable while valid is held.
REQ-023 bready_o SHALL be 1 only in RESP.
REQ-024 On bvalid_i in RESP, wr_ptr_o SHALL increment modulo RING_LINES, the slots and idle counter SHALL clear, and the state SHALL return to FILL.
REQ-025 A bresp_i value other than 2'b00 SHALL set err_o, and the pointer SHALL still advance.
REQ-026 Latency from the 4th accepted packet to awvalid_o SHALL be 1 cycle, given the ring is not full.
REQ-027 wr_ptr_o SHALL wrap from RING_LINES-1 to 0, and the high pointer bits SHALL be zero.
REQ-028 rd_ptr_i changes SHALL take effect on the full check in the same cycle.
REQ-029 The block SHALL have exactly one outstanding write at a time.

Reset
REQ-030 When resetn_i is 0 at a clock edge, the next cycle SHALL show state FILL, slots empty, idle counter 0, wr_ptr_o 0, err_o 0, fsb_r_o 1, and awvalid_o, wvalid_o and bready_o at 0.
REQ-031 A reset in any state, including mid-SEND or RESP, SHALL discard the partial line and drop AXI valids; the block SHALL not resume the interrupted transaction.

Verification
REQ-032 Bench SHALL drive 4 back-to-back packets 80'h1..80'h4 with awready/wready tied 1 -> one write to BASE_ADDR, wdata[79:0]=1 and wdata[463:384]=4, wstrb all ones, wr_ptr_o=1 after bvalid.
REQ-033 Bench SHALL drive a single packet followed by idle with TIMEOUT=16 -> write issued after 16 idle cycles, wstrb=64'h000000000000FFFF.
REQ-034 Bench SHALL set rd_ptr_i=0 and fill RING_LINES-1 lines -> the next full line is held, fsb_r_o=0 and no awvalid; setting rd_ptr_i=1 -> write issues to BASE_ADDR+(RING_LINES-1)*64 and wr_ptr_o wraps to 0.
REQ-035 Bench SHALL delay wready 5 cycles after awready with awready=1 -> awvalid drops after 1 cycle, wvalid held 5 cycles, single transaction, enters RESP.
REQ-036 Bench SHALL return bresp=2'b10 -> err_o=1 sticky, wr_ptr_o advances; reset -> err_o=0.
REQ-037 Bench SHALL assert reset while awvalid is pending -> awvalid_o=0 the next cycle, wr_ptr_o=0, fsb_r_o=1.
